// File: rtl/ps2_kbd_rxfifo_if.sv
// Key-event side of the PS/2 receiver: pop strobe in, FIFO head, modifier state and status pulses out.
// The master modport is the receiver; the slave modport is the consumer.
interface ps2_kbd_rxfifo_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic               iRead;
    logic               oEmpty;
    logic [7:0]         oData;
    logic               oBreak;
    logic               oExt;
    logic [FIFO_AW:0]   oCount;
    logic [5:0]         oTag;
    logic               oErr;
    logic               oOverflow;

    modport master (
        input  iRead,
        output oEmpty, oData, oBreak, oExt, oCount, oTag, oErr, oOverflow
    );

    modport slave (
        output iRead,
        input  oEmpty, oData, oBreak, oExt, oCount, oTag, oErr, oOverflow
    );
endinterface

// File: rtl/ps2_kbd_rxfifo.sv
// PS/2 keyboard receiver: filtered clock, framed byte capture with timeout, E0/F0 prefix decode,
// modifier tracking and a show-ahead FIFO of make/break events.
module ps2_kbd_rxfifo #(
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned TIMEOUT      = 50000,
    parameter int unsigned FIFO_AW      = 3,
    parameter bit          CHECK_PARITY = 1'b1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    ps2_kbd_rxfifo_if.master bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_flt_lvl;
    logic [3:0]    r_flt_cnt;
    logic          w_fall;

    state_e        r_state;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    logic          r_err;

    logic          r_ext, r_brk;
    logic [5:0]    r_tag;
    logic          r_ovf;
    logic [9:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    logic [5:0]    w_mod_bit;
    logic          w_push_req, w_push, w_pop, w_full;
    logic [9:0]    w_head;

    // A fall is the cycle in which the filter commits the 1->0 level change.
    assign w_fall = r_flt_lvl && !r_clk_s2 && (r_flt_cnt == 4'(FILTER_LEN - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_flt_lvl <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_flt_lvl) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == 4'(FILTER_LEN - 1)) begin
                r_flt_lvl <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to       <= '0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            if (r_state == StIdle) begin
                r_to <= '0;
                if (w_fall && !r_dat_s2) begin
                    r_state <= StData;
                    r_bit   <= '0;
                end
            end else if (w_fall) begin
                r_to <= '0;
                unique case (r_state)
                    StData: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= StParity;
                    end
                    StParity: begin
                        r_par   <= r_dat_s2;
                        r_state <= StStop;
                    end
                    StStop: begin
                        r_state <= StIdle;
                        if (r_dat_s2 && (!CHECK_PARITY || ^{r_shift, r_par})) begin
                            r_byte_vld <= 1'b1;
                            r_byte     <= r_shift;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end else if (r_to == TW'(TIMEOUT - 1)) begin
                r_err   <= 1'b1;
                r_state <= StIdle;
                r_to    <= '0;
            end else begin
                r_to <= r_to + TW'(1);
            end
        end
    end

    // Modifier keys map to a one-hot tag bit; anything else is a queued event.
    always_comb begin
        w_mod_bit = '0;
        if (!r_ext) begin
            unique case (r_byte)
                8'h11:   w_mod_bit = 6'b000001;
                8'h14:   w_mod_bit = 6'b000010;
                8'h12:   w_mod_bit = 6'b000100;
                8'h59:   w_mod_bit = 6'b100000;
                default: w_mod_bit = '0;
            endcase
        end else begin
            unique case (r_byte)
                8'h11:   w_mod_bit = 6'b001000;
                8'h14:   w_mod_bit = 6'b010000;
                default: w_mod_bit = '0;
            endcase
        end
    end

    assign w_push_req = r_byte_vld && (r_byte != 8'hE0) && (r_byte != 8'hF0) && (w_mod_bit == '0);
    assign w_pop      = bus.iRead && (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_tag   <= '0;
            r_ovf   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_ovf <= w_push_req && !w_push;
            if (r_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    r_tag <= r_brk ? (r_tag & ~w_mod_bit) : (r_tag | w_mod_bit);
                end
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (w_push) r_mem[r_wptr] <= {r_ext, r_brk, r_byte};
    end

    assign w_head        = r_mem[r_rptr];
    assign bus.oEmpty    = (r_count == '0);
    assign bus.oData     = bus.oEmpty ? 8'h00 : w_head[7:0];
    assign bus.oBreak    = bus.oEmpty ? 1'b0 : w_head[8];
    assign bus.oExt      = bus.oEmpty ? 1'b0 : w_head[9];
    assign bus.oCount    = r_count;
    assign bus.oTag      = r_tag;
    assign bus.oErr      = r_err;
    assign bus.oOverflow = r_ovf;
endmodule

// File: tb/tb_ps2_kbd_rxfifo.sv
// Bench for ps2_kbd_rxfifo: byte-level reference model of prefixes, modifiers and the event queue,
// directed scenarios plus a randomized key stream, compared against the DUT every idle cycle.
module tb_ps2_kbd_rxfifo;
    localparam int unsigned H       = 10;
    localparam int unsigned TIMEOUT = 400;
    localparam int unsigned DEPTH   = 8;

    logic CLOCK, RESET, PS2_CLK, PS2_DAT;
    ps2_kbd_rxfifo_if #(.FIFO_AW(3)) bus ();

    ps2_kbd_rxfifo #(
        .FILTER_LEN  (4),
        .TIMEOUT     (TIMEOUT),
        .FIFO_AW     (3),
        .CHECK_PARITY(1'b1)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .PS2_CLK(PS2_CLK),
        .PS2_DAT(PS2_DAT),
        .bus    (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errs = 0;
    bit chk_en = 1'b0;
    logic [9:0] m_q[$];
    logic [5:0] m_tag;
    bit m_ext, m_brk;
    int m_err = 0, m_ovf = 0;
    int n_err_seen = 0, n_ovf_seen = 0;
    logic [7:0] mods [4] = '{8'h11, 8'h12, 8'h14, 8'h59};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            if (n_errs <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [9:0] head();
        return {bus.oExt, bus.oBreak, bus.oData};
    endfunction

    // Reference decoder: one received byte at a time.
    task automatic model_byte(input logic [7:0] b);
        int mi;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            mi = -1;
            if (!m_ext) begin
                if (b == 8'h12) mi = 2;
                if (b == 8'h14) mi = 1;
                if (b == 8'h11) mi = 0;
                if (b == 8'h59) mi = 5;
            end else begin
                if (b == 8'h14) mi = 4;
                if (b == 8'h11) mi = 3;
            end
            if (mi >= 0) m_tag[mi] = !m_brk;
            else if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
            else m_ovf++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(negedge CLOCK) begin
        if (bus.oErr) n_err_seen++;
        if (bus.oOverflow) n_ovf_seen++;
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check("count", 32'(bus.oCount), m_q.size());
            check("empty", 32'(bus.oEmpty), 32'(m_q.size() == 0));
            check("tag", 32'(bus.oTag), 32'(m_tag));
            check("err_idle", 32'(bus.oErr), 0);
            check("ovf_idle", 32'(bus.oOverflow), 0);
            if (m_q.size() > 0) check("head", 32'(head()), 32'(m_q[0]));
            else check("head_empty", 32'(head()), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        PS2_DAT = b;
        if (glitch) begin
            tick(3);
            PS2_CLK = 1'b0;
            tick(2);
            PS2_CLK = 1'b1;
            tick(H - 5);
        end else begin
            tick(H);
        end
        PS2_CLK = 1'b0;
        tick(H);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push,
                              input bit chk_lat, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        chk_en = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(bits[i], glitch);
        PS2_DAT = 1'b1;
        tick(H);
        PS2_CLK = 1'b0;
        if (pop_at_push) begin
            tick(6);
            bus.iRead = 1'b1;
            tick(1);
            bus.iRead = 1'b0;
            tick(H - 7);
        end else if (chk_lat) begin
            tick(6);
            @(negedge CLOCK);
            check("lat_n1_empty", 32'(bus.oEmpty), 1);
            @(posedge CLOCK);
            #1;
            @(negedge CLOCK);
            check("lat_n2_empty", 32'(bus.oEmpty), 0);
            check("lat_n2_count", 32'(bus.oCount), 1);
            tick(H - 8);
        end else begin
            tick(H);
        end
        PS2_CLK = 1'b1;
        if (bad_par) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            if (pop_at_push && m_q.size() > 0) void'(m_q.pop_front());
            model_byte(b);
        end
        tick(2);
        chk_en = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_partial(input int nbits, input bit stall);
        chk_en = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'b1, 1'b0);
        PS2_DAT = 1'b1;
        if (stall) begin
            tick(TIMEOUT + 20);
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
            chk_en = 1'b1;
        end
    endtask

    task automatic pop_one();
        bus.iRead = 1'b1;
        tick(1);
        bus.iRead = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
        m_q.delete();
        m_tag = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(1);
        chk_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_errs=%0d", n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        bit ext, brk, bad;
        int base_ovf;
        RESET = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        bus.iRead = 1'b0;
        m_tag = '0;
        do_reset();
        @(negedge CLOCK);
        check("rst_empty", 32'(bus.oEmpty), 1);
        check("rst_count", 32'(bus.oCount), 0);
        check("rst_tag", 32'(bus.oTag), 0);
        check("rst_data", 32'(bus.oData), 0);
        tick(1);

        // Single make code with latency pinned.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_head", 32'(head()), 32'h01C);
        pop_one();
        tick(1);
        check("t1_empty", 32'(bus.oEmpty), 1);
        pop_one();

        // Left shift around A make/break.
        send(8'h12);
        check("t2_lshift", 32'(bus.oTag), 32'h04);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        check("t2_tag_clr", 32'(bus.oTag), 0);
        check("t2_count", 32'(bus.oCount), 2);
        check("t2_head0", 32'(head()), 32'h01C);
        pop_one();
        check("t2_head1", 32'(head()), 32'h11C);
        pop_one();

        // Extended right ctrl and keypad-up.
        send(8'hE0); send(8'h14);
        check("t3_rctrl", 32'(bus.oTag), 32'h10);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("t3_tag_clr", 32'(bus.oTag), 0);
        check("t3_head0", 32'(head()), 32'h275);
        pop_one();
        check("t3_head1", 32'(head()), 32'h375);
        pop_one();

        // Parity error, then timeout after a break prefix.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_err_par", n_err_seen, 1);
        send(8'hF0);
        send_partial(3, 1'b1);
        check("t4_err_to", n_err_seen, 2);
        send(8'h1C);
        check("t4_make", 32'(head()), 32'h01C);
        pop_one();

        // Overflow and simultaneous push/pop when full.
        base_ovf = n_ovf_seen;
        for (int i = 0; i < 9; i++) send(8'(8'h15 + i));
        check("t5_count", 32'(bus.oCount), 8);
        check("t5_ovf", n_ovf_seen - base_ovf, 1);
        check("t5_head", 32'(head()), 32'h015);
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_pp_count", 32'(bus.oCount), 8);
        check("t5_pp_ovf", n_ovf_seen - base_ovf, 1);
        check("t5_pp_head", 32'(head()), 32'h016);
        repeat (9) pop_one();

        // Glitched clock, then reset mid-frame.
        send_frame(8'h3B, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_glitch", 32'(head()), 32'h03B);
        send(8'h59);
        send_partial(4, 1'b0);
        do_reset();
        check("t6_rst_tag", 32'(bus.oTag), 0);
        tick(H);
        send(8'h4D);
        check("t6_after_rst", 32'(head()), 32'h04D);
        check("t6_no_err", n_err_seen, m_err);
        pop_one();

        // Randomized key stream.
        for (int e = 0; e < 40; e++) begin
            if ($urandom_range(0, 3) == 0) code = mods[$urandom_range(0, 3)];
            else begin
                do code = 8'($urandom); while (code == 8'hE0 || code == 8'hF0);
            end
            ext = 1'($urandom_range(0, 1));
            brk = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 14) == 0);
            if (ext) send(8'hE0);
            if (brk) send(8'hF0);
            send_frame(code, bad, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) pop_one();
        end
        check("rnd_err_cnt", n_err_seen, m_err);
        check("rnd_ovf_cnt", n_ovf_seen, m_ovf);
        repeat (9) pop_one();
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
